// File: rtl/lsu_pkg.sv
// Shared constants and helpers for the load/store unit memory master:
// funct3 encodings, FSM state codes and request legality checks.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RD   = 2'd1;
  localparam logic [1:0] ST_WR   = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  // Access size comes from funct3[1:0]; the offset must be a multiple of it.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [2:0] off);
    logic mis;
    case (funct3[1:0])
      2'b00:   mis = 1'b0;
      2'b01:   mis = off[0];
      2'b10:   mis = |off[1:0];
      default: mis = |off;
    endcase
    return mis;
  endfunction

  // Loads reject 111 only; stores only exist for widths 000..011.
  function automatic logic is_illegal(input logic store, input logic [2:0] funct3);
    return store ? funct3[2] : (funct3 == 3'b111);
  endfunction

  // Offset used when alignment checking is disabled: low bits below the
  // access size are dropped.
  function automatic logic [2:0] force_align(input logic [2:0] funct3, input logic [2:0] off);
    logic [2:0] r;
    case (funct3[1:0])
      2'b00:   r = off;
      2'b01:   r = {off[2:1], 1'b0};
      2'b10:   r = {off[2], 2'b00};
      default: r = 3'b000;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Byte-lane steering for a doubleword-wide memory: extracts and extends
// load data, and merges sub-doubleword store data into an old dword.
module lsu_byte_lane
  import lsu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] rd_dword,
  input  logic [XLEN-1:0] wdata,
  input  logic [2:0]      offset,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] load_val,
  output logic [XLEN-1:0] merged
);

  logic [5:0]      sh;
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] lane_mask;
  logic [XLEN-1:0] mask;

  function automatic logic [XLEN-1:0] sext8(input logic signed [7:0] v);
    logic signed [XLEN-1:0] r;
    r = v;
    return r;
  endfunction

  function automatic logic [XLEN-1:0] sext16(input logic signed [15:0] v);
    logic signed [XLEN-1:0] r;
    r = v;
    return r;
  endfunction

  function automatic logic [XLEN-1:0] sext32(input logic signed [31:0] v);
    logic signed [XLEN-1:0] r;
    r = v;
    return r;
  endfunction

  // Load extraction: shift the addressed lane down, then extend by funct3.
  always_comb begin
    sh      = {offset, 3'b000};
    shifted = rd_dword >> sh;
    case (funct3)
      F3_B:    load_val = sext8(shifted[7:0]);
      F3_H:    load_val = sext16(shifted[15:0]);
      F3_W:    load_val = sext32(shifted[31:0]);
      F3_BU:   load_val = {{(XLEN-8){1'b0}}, shifted[7:0]};
      F3_HU:   load_val = {{(XLEN-16){1'b0}}, shifted[15:0]};
      F3_WU:   load_val = {{(XLEN-32){1'b0}}, shifted[31:0]};
      F3_D:    load_val = shifted;
      default: load_val = shifted;
    endcase
  end

  // Store merge: replace only the lanes covered by the access width.
  always_comb begin
    case (funct3[1:0])
      2'b00:   lane_mask = {{(XLEN-8){1'b0}}, 8'hFF};
      2'b01:   lane_mask = {{(XLEN-16){1'b0}}, 16'hFFFF};
      2'b10:   lane_mask = {{(XLEN-32){1'b0}}, 32'hFFFF_FFFF};
      default: lane_mask = {XLEN{1'b1}};
    endcase
    mask   = lane_mask << sh;
    merged = (rd_dword & ~mask) | ((wdata << sh) & mask);
  end

endmodule

// File: rtl/lsu_mem_master.sv
// Memory-port initiator for RV64 loads/stores. One request at a time;
// sub-doubleword stores use read-modify-write on the dword-wide memory.
module lsu_mem_master
  import lsu_pkg::*;
#(
  parameter int XLEN        = 64,
  parameter bit CHECK_ALIGN = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_store,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err,
  output logic            mem_read,
  output logic            mem_write,
  output logic [XLEN-1:0] mem_address,
  output logic [XLEN-1:0] mem_write_data,
  input  logic [XLEN-1:0] mem_read_data
);

  logic [1:0]      state;
  logic            acc_err;
  logic [2:0]      acc_off;

  logic            store_p0;
  logic [2:0]      funct3_p0;
  logic [2:0]      offset_p0;
  logic [XLEN-1:0] wdata_p0;

  logic [XLEN-1:0] load_val;
  logic [XLEN-1:0] merged;

  // Acceptance decode: legality and the lane offset the access will use.
  always_comb begin
    req_ready = (state == ST_IDLE);
    acc_off   = CHECK_ALIGN ? req_addr[2:0] : force_align(req_funct3, req_addr[2:0]);
    acc_err   = is_illegal(req_store, req_funct3) |
                (CHECK_ALIGN & is_misaligned(req_funct3, req_addr[2:0]));
  end

  // Request capture stage: inputs are frozen at acceptance.
  always_ff @(posedge clk) begin
    if (req_ready && req_valid) begin
      store_p0  <= req_store;
      funct3_p0 <= req_funct3;
      offset_p0 <= acc_off;
      wdata_p0  <= req_wdata;
    end
  end

  lsu_byte_lane #(.XLEN(XLEN)) u_lane (
    .rd_dword (mem_read_data),
    .wdata    (wdata_p0),
    .offset   (offset_p0),
    .funct3   (funct3_p0),
    .load_val (load_val),
    .merged   (merged)
  );

  // Control FSM driving registered memory strobes and response outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= ST_IDLE;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      mem_address    <= '0;
      mem_write_data <= '0;
      resp_valid     <= 1'b0;
      resp_err       <= 1'b0;
      resp_rdata     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            if (acc_err) begin
              state      <= ST_RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else begin
              mem_address <= {req_addr[XLEN-1:3], 3'b000};
              if (req_store && (req_funct3[1:0] == 2'b11)) begin
                state          <= ST_WR;
                mem_write      <= 1'b1;
                mem_write_data <= req_wdata;
              end else begin
                state    <= ST_RD;
                mem_read <= 1'b1;
              end
            end
          end
        end
        ST_RD: begin
          mem_read <= 1'b0;
          if (store_p0) begin
            state          <= ST_WR;
            mem_write      <= 1'b1;
            mem_write_data <= merged;
          end else begin
            state      <= ST_RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= load_val;
          end
        end
        ST_WR: begin
          state      <= ST_RESP;
          mem_write  <= 1'b0;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
        end
        ST_RESP: begin
          if (resp_ready) begin
            state      <= ST_IDLE;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Bench for lsu_mem_master: byte-array reference model, directed cases
// followed by random loads/stores, and an async reset abort.
module tb_lsu_mem_master;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_store = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [63:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic        mem_read;
  logic        mem_write;
  logic [63:0] mem_address;
  logic [63:0] mem_write_data;
  logic [63:0] mem_read_data;

  logic [63:0] tbmem [0:15];
  logic        pre_we = 1'b0;
  logic [3:0]  pre_idx = '0;
  logic [63:0] pre_data = '0;
  logic [7:0]  ref_b [0:127];

  int total = 0;
  int passed = 0;
  int failed = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  int both_cnt = 0;
  int bad_addr_cnt = 0;
  logic [63:0] rd_addr_seen = '0;
  logic [63:0] wr_addr_seen = '0;
  logic [63:0] wr_data_seen = '0;

  lsu_mem_master #(.XLEN(64), .CHECK_ALIGN(1'b1)) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_store      (req_store),
    .req_funct3     (req_funct3),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_rdata     (resp_rdata),
    .resp_err       (resp_err),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data)
  );

  always #5 clk = ~clk;

  assign mem_read_data = tbmem[mem_address[6:3]];

  // Memory model plus strobe monitor.
  always @(posedge clk) begin
    if (pre_we) tbmem[pre_idx] <= pre_data;
    else if (mem_write) tbmem[mem_address[6:3]] <= mem_write_data;
    if (mem_read) begin
      rd_cnt = rd_cnt + 1;
      rd_addr_seen = mem_address;
    end
    if (mem_write) begin
      wr_cnt = wr_cnt + 1;
      wr_addr_seen = mem_address;
      wr_data_seen = mem_write_data;
    end
    if (mem_read && mem_write) both_cnt = both_cnt + 1;
    if ((mem_read || mem_write) && ((mem_address[63:7] != '0) || (mem_address[2:0] != 3'b000)))
      bad_addr_cnt = bad_addr_cnt + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_dword(input int base);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < 8; i++) v[8*i +: 8] = ref_b[(base & ~7) + i];
    return v;
  endfunction

  // Reference load: gather bytes little-endian, extend per funct3.
  function automatic logic [63:0] ref_load(input logic [2:0] f3, input int a);
    logic [63:0] v;
    int size;
    size = 1 << f3[1:0];
    v = '0;
    for (int i = 0; i < size; i++) v[8*i +: 8] = ref_b[a + i];
    if (!f3[2] && size < 8 && v[8*size-1]) begin
      for (int i = size * 8; i < 64; i++) v[i] = 1'b1;
    end
    return v;
  endfunction

  task automatic do_op(input logic st, input logic [2:0] f3, input int a,
                       input logic [63:0] wd, input int hold, output logic [63:0] got);
    int size;
    logic e_err;
    int e_lat;
    int e_rd;
    int e_wr;
    logic [63:0] e_rdata;
    int lat;
    int rd0;
    int wr0;
    logic [63:0] r0;
    size = 1 << f3[1:0];
    e_err = (st ? f3[2] : (f3 == 3'b111)) || ((a % size) != 0);
    e_rd = (e_err || (st && size == 8)) ? 0 : 1;
    e_wr = (!e_err && st) ? 1 : 0;
    e_lat = e_err ? 1 : (!st ? 2 : (size == 8 ? 2 : 3));
    e_rdata = (!e_err && !st) ? ref_load(f3, a) : 64'd0;
    check("req_ready_idle", {63'd0, req_ready}, 64'd1);
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    req_valid = 1'b1;
    req_store = st;
    req_funct3 = f3;
    req_addr = 64'(a);
    req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_store = 1'($urandom);
    req_funct3 = 3'($urandom);
    req_addr = {$urandom, $urandom};
    req_wdata = {$urandom, $urandom};
    lat = 1;
    while (!resp_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 64'(lat), 64'(e_lat));
    check("resp_valid", {63'd0, resp_valid}, 64'd1);
    check("resp_err", {63'd0, resp_err}, {63'd0, e_err});
    check("resp_rdata", resp_rdata, e_rdata);
    r0 = resp_rdata;
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      check("hold_valid", {63'd0, resp_valid}, 64'd1);
      check("hold_rdata", resp_rdata, r0);
      check("hold_req_ready", {63'd0, req_ready}, 64'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check("post_hs_valid", {63'd0, resp_valid}, 64'd0);
    check("post_hs_ready", {63'd0, req_ready}, 64'd1);
    check("read_pulses", 64'(rd_cnt - rd0), 64'(e_rd));
    check("write_pulses", 64'(wr_cnt - wr0), 64'(e_wr));
    if (e_rd == 1) check("read_addr", rd_addr_seen, 64'(a & ~7));
    if (e_wr == 1) begin
      check("write_addr", wr_addr_seen, 64'(a & ~7));
      for (int i = 0; i < size; i++) ref_b[a + i] = wd[8*i +: 8];
      check("write_data", wr_data_seen, ref_dword(a));
    end
    check("mem_dword", tbmem[(a >> 3) & 15], ref_dword(a));
    got = r0;
  endtask

  initial begin
    logic [63:0] got;
    logic [63:0] d;
    logic        st;
    logic [2:0]  f3;
    int          a;
    int          sz;

    #1;
    check("rst_mem_read", {63'd0, mem_read}, 64'd0);
    check("rst_mem_write", {63'd0, mem_write}, 64'd0);
    check("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
    check("rst_resp_err", {63'd0, resp_err}, 64'd0);
    check("rst_mem_address", mem_address, 64'd0);
    check("rst_mem_wdata", mem_write_data, 64'd0);
    check("rst_resp_rdata", resp_rdata, 64'd0);
    check("rst_req_ready", {63'd0, req_ready}, 64'd1);

    // Preload memory and the reference while reset is held.
    for (int i = 0; i < 16; i++) begin
      d = (i == 2) ? 64'h8877665544332211 : {$urandom, $urandom};
      for (int b = 0; b < 8; b++) ref_b[i*8 + b] = d[8*b +: 8];
      pre_we = 1'b1;
      pre_idx = 4'(i);
      pre_data = d;
      @(posedge clk); #1;
    end
    pre_we = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;

    // Directed loads on the preloaded dword.
    do_op(1'b0, 3'b000, 'h17, 64'd0, 0, got);
    check("lb_lit", got, 64'hFFFFFFFFFFFFFF88);
    do_op(1'b0, 3'b100, 'h17, 64'd0, 0, got);
    check("lbu_lit", got, 64'h88);
    do_op(1'b0, 3'b001, 'h12, 64'd0, 0, got);
    check("lh_lit", got, 64'h4433);
    do_op(1'b0, 3'b110, 'h14, 64'd0, 0, got);
    check("lwu_lit", got, 64'h88776655);

    // Read-modify-write halfword store, then read back.
    do_op(1'b1, 3'b001, 'h12, 64'h000000000000BEEF, 0, got);
    check("sh_merge_lit", wr_data_seen, 64'h88776655BEEF2211);
    do_op(1'b0, 3'b011, 'h10, 64'd0, 0, got);
    check("ld_after_sh", got, 64'h88776655BEEF2211);

    // Full doubleword store and read back.
    do_op(1'b1, 3'b011, 'h18, 64'hDEADBEEFCAFEF00D, 1, got);
    do_op(1'b0, 3'b011, 'h18, 64'd0, 0, got);
    check("ld_after_sd", got, 64'hDEADBEEFCAFEF00D);

    // Errors: misaligned word, illegal load funct3, illegal store funct3.
    do_op(1'b0, 3'b010, 'h13, 64'd0, 0, got);
    do_op(1'b0, 3'b111, 'h10, 64'd0, 0, got);
    do_op(1'b1, 3'b100, 'h10, 64'h55, 2, got);

    // Response backpressure.
    do_op(1'b0, 3'b011, 'h10, 64'd0, 5, got);

    // Random traffic.
    for (int n = 0; n < 60; n++) begin
      st = 1'($urandom);
      f3 = 3'($urandom_range(0, 7));
      sz = 1 << f3[1:0];
      a = $urandom_range(0, 127 - 7);
      if ($urandom_range(0, 3) != 0) a = a & ~(sz - 1);
      do_op(st, f3, a, {$urandom, $urandom}, $urandom_range(0, 3), got);
    end

    // Async reset in the read phase of a byte store aborts the write.
    begin
      int wr0;
      wr0 = wr_cnt;
      req_valid = 1'b1;
      req_store = 1'b1;
      req_funct3 = 3'b000;
      req_addr = 64'h21;
      req_wdata = 64'h5A ^ {56'd0, ref_b['h21]};
      @(posedge clk); #1;
      req_valid = 1'b0;
      check("abort_in_rd", {63'd0, mem_read}, 64'd1);
      #2;
      reset = 1'b1;
      #1;
      check("abort_mem_read", {63'd0, mem_read}, 64'd0);
      check("abort_mem_write", {63'd0, mem_write}, 64'd0);
      check("abort_resp_valid", {63'd0, resp_valid}, 64'd0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("abort_req_ready", {63'd0, req_ready}, 64'd1);
      check("abort_no_write", 64'(wr_cnt - wr0), 64'd0);
      check("abort_mem_dword", tbmem[4], ref_dword('h20));
    end

    check("never_both_strobes", 64'(both_cnt), 64'd0);
    check("strobe_addr_aligned", 64'(bad_addr_cnt), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
